// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a 1-cycle result register and
// a one-entry skid buffer. Supports XLEN of 32 or 64 only.
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  seinst,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic       RV64    = (XLEN == 64);
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } res_t;

  logic [6:0]         opc;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic [XLEN-1:0]    shamt_op;
  logic [XLEN-1:0]    shamt_w;
  res_t               dec_res;

  assign opc      = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_i    = instruction[31:20];
  assign imm_s    = {instruction[31:25], instruction[11:7]};
  assign imm_b    = {instruction[31], instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
  assign imm_u    = {instruction[31:12], 12'b0};
  assign imm_j    = {instruction[31], instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
  // RV64 OP-IMM shifts carry a 6-bit shamt; the word variants only 5 bits.
  assign shamt_op = RV64 ? XLEN'(instruction[25:20]) : XLEN'(instruction[24:20]);
  assign shamt_w  = XLEN'(instruction[24:20]);

  always_comb begin
    dec_res     = '0;
    dec_res.fmt = FMT_ILL;
    dec_res.ill = 1'b1;
    case (opc)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_res.imm = XLEN'(imm_i);
        dec_res.fmt = FMT_I;
        dec_res.ill = 1'b0;
      end
      7'b0010011: begin
        dec_res.imm = is_shift ? shamt_op : XLEN'(imm_i);
        dec_res.fmt = FMT_I;
        dec_res.ill = 1'b0;
      end
      7'b0011011: begin
        if (RV64) begin
          dec_res.imm = is_shift ? shamt_w : XLEN'(imm_i);
          dec_res.fmt = FMT_I;
          dec_res.ill = 1'b0;
        end
      end
      7'b0100011: begin
        dec_res.imm = XLEN'(imm_s);
        dec_res.fmt = FMT_S;
        dec_res.ill = 1'b0;
      end
      7'b1100011: begin
        dec_res.imm = XLEN'(imm_b);
        dec_res.fmt = FMT_B;
        dec_res.ill = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_res.imm = XLEN'(imm_u);
        dec_res.fmt = FMT_U;
        dec_res.ill = 1'b0;
      end
      7'b1101111: begin
        dec_res.imm = XLEN'(imm_j);
        dec_res.fmt = FMT_J;
        dec_res.ill = 1'b0;
      end
      7'b0110011: begin
        dec_res.fmt = FMT_R;
        dec_res.ill = 1'b0;
      end
      7'b0111011: begin
        if (RV64) begin
          dec_res.fmt = FMT_R;
          dec_res.ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  res_t             out_q, out_d, skid_q, skid_d;
  logic             out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, xfer;

  // in_ready comes straight from the skid-valid flop, never from out_ready.
  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_v_q & out_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!out_v_q || xfer) begin
      // The skid entry is older than anything arriving now, so it goes first;
      // accept cannot coincide with a full skid since in_ready is then low.
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        out_d   = dec_res;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec_res;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = out_v_q;
  assign seinst     = out_q.imm;
  assign fmt        = out_q.fmt;
  assign illegal    = out_q.ill;
  assign xfer_count = cnt_q;

endmodule

`default_nettype wire
